// File: rtl/systolic_pkg.sv
// Shared constants for the systolic array datapath (input skew stage, PE array
// and receive-side deskew).
//   LANES  - number of PE lanes
//   WIDTH  - bits per lane
//   CNT_W  - default width of per-frame vector counters
//   VEC_W  - width of a full lane vector
package systolic_pkg;

  localparam int unsigned LANES = 16;
  localparam int unsigned WIDTH = 5;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned VEC_W = LANES * WIDTH;

  // Bit offset of lane 'lane' inside a packed vector of 'width'-bit lanes.
  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
    return lane * width;
  endfunction

endpackage

// File: rtl/lane_delay.sv
// Fixed-depth register chain for one lane of the deskew stage. No reset: the
// contents are only meaningful when qualified by the valid chain in the top.
// DEPTH = 0 collapses to a wire.
//   i_clk  - rising-edge clock
//   i_data - lane input
//   o_data - lane input delayed by DEPTH cycles
module lane_delay #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned WIDTH = 5
) (
  input  logic             i_clk,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  if (DEPTH == 0) begin : g_wire
    logic w_unused_clk;
    assign w_unused_clk = i_clk;
    assign o_data       = i_data;
  end else begin : g_regs
    logic [WIDTH-1:0] r_stage [DEPTH];

    always_ff @(posedge i_clk) begin
      r_stage[0] <= i_data;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end

    assign o_data = r_stage[DEPTH-1];
  end

endmodule

// File: rtl/systolic_deskew.sv
// Receive-side deskew for the systolic PE array. Lane k of a vector arrives k
// cycles after lane 0; each lane is delayed by LANES-1-k cycles so all lanes
// leave together through one common output register.
//   clk       - rising-edge clock
//   rst       - synchronous active-high reset
//   in_valid  - lane 0 of a new vector is on in_data this cycle
//   in_last   - with in_valid: last vector of the frame
//   in_data   - skewed lanes, lane k at [k*WIDTH +: WIDTH]
//   out_valid - aligned vector on out_data
//   out_last  - with out_valid: last vector of the frame
//   out_data  - aligned vector (0 when out_valid is low)
//   out_count - vectors emitted so far in the current frame (saturating)
//   busy      - at least one vector still inside the delay chain
module systolic_deskew #(
  parameter int unsigned LANES = systolic_pkg::LANES,
  parameter int unsigned WIDTH = systolic_pkg::WIDTH,
  parameter int unsigned CNT_W = systolic_pkg::CNT_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic                   in_last,
  input  logic [LANES*WIDTH-1:0] in_data,
  output logic                   out_valid,
  output logic                   out_last,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic [CNT_W-1:0]       out_count,
  output logic                   busy
);

  import systolic_pkg::*;

  logic [LANES*WIDTH-1:0] w_aligned;
  logic                   w_tail_valid;
  logic                   w_tail_last;
  logic                   w_busy;
  logic [CNT_W-1:0]       w_count_base;
  logic [CNT_W-1:0]       w_count_d;

  logic                   r_out_valid;
  logic                   r_out_last;
  logic [LANES*WIDTH-1:0] r_out_data;
  logic [CNT_W-1:0]       r_count;

  // Per-lane delay lines: the latest lane gets no delay stages.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    lane_delay #(
      .DEPTH(LANES - 1 - k),
      .WIDTH(WIDTH)
    ) u_lane_delay (
      .i_clk (clk),
      .i_data(in_data[lane_lsb(k, WIDTH) +: WIDTH]),
      .o_data(w_aligned[lane_lsb(k, WIDTH) +: WIDTH])
    );
  end

  // Valid/last chain matching the lane-0 delay; its tail lines up with the
  // moment the last lane is presented.
  if (LANES > 1) begin : g_chain
    logic [LANES-2:0] r_vld;
    logic [LANES-2:0] r_lst;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_vld <= '0;
        r_lst <= '0;
      end else begin
        r_vld[0] <= in_valid;
        r_lst[0] <= in_valid & in_last;
        for (int unsigned i = 1; i < LANES - 1; i++) begin
          r_vld[i] <= r_vld[i-1];
          r_lst[i] <= r_lst[i-1];
        end
      end
    end

    assign w_tail_valid = r_vld[LANES-2];
    assign w_tail_last  = r_lst[LANES-2];
    assign w_busy       = |r_vld;
  end else begin : g_no_chain
    assign w_tail_valid = in_valid;
    assign w_tail_last  = in_valid & in_last;
    assign w_busy       = 1'b0;
  end

  // A new frame starts on the vector after one flagged last.
  always_comb begin
    w_count_base = (r_out_valid && r_out_last) ? '0 : r_count;
    w_count_d    = w_count_base;
    if (w_tail_valid && (w_count_base != {CNT_W{1'b1}})) begin
      w_count_d = w_count_base + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
      r_count     <= '0;
    end else begin
      r_out_valid <= w_tail_valid;
      r_out_last  <= w_tail_valid & w_tail_last;
      r_out_data  <= w_tail_valid ? w_aligned : '0;
      r_count     <= w_count_d;
    end
  end

  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign out_data  = r_out_data;
  assign out_count = r_count;
  assign busy      = w_busy;

endmodule

// File: tb/tb_systolic_deskew.sv
module tb_systolic_deskew;

  localparam int LANES = 16;
  localparam int WIDTH = 5;
  localparam int CNT_W = 16;
  localparam int DW    = LANES * WIDTH;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_last;
  logic [DW-1:0]    in_data;
  logic             out_valid;
  logic             out_last;
  logic [DW-1:0]    out_data;
  logic [CNT_W-1:0] out_count;
  logic             busy;

  systolic_deskew #(
    .LANES(LANES),
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_last (out_last),
    .out_data (out_data),
    .out_count(out_count),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               cyc;
    logic [DW-1:0]    data;
    logic             last;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t             sb[$];
  logic [DW-1:0]    hist [LANES];
  int               cyc = 0;
  int               errors = 0;
  int               checks = 0;
  logic [CNT_W-1:0] frame_cnt = '0;
  logic [CNT_W-1:0] idle_cnt = '0;

  // Upstream skew-stage model: lane k of in_data comes from the word
  // launched k cycles earlier. Expected outputs are pushed here.
  task automatic drive(input logic v, input logic l, input logic [DW-1:0] w, input logic r);
    exp_t        n;
    logic [95:0] rnd;
    rnd = {$urandom(), $urandom(), $urandom()};
    for (int i = LANES - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = v ? w : rnd[DW-1:0];
    for (int k = 0; k < LANES; k++) in_data[k*WIDTH +: WIDTH] = hist[k][k*WIDTH +: WIDTH];
    in_valid = v;
    in_last  = l;
    rst      = r;
    if (r) begin
      sb.delete();
      frame_cnt = '0;
      idle_cnt  = '0;
    end else if (v) begin
      n.cyc  = cyc + LANES;
      n.data = w;
      n.last = l;
      n.cnt  = (frame_cnt == {CNT_W{1'b1}}) ? frame_cnt : frame_cnt + 1'b1;
      frame_cnt = l ? '0 : n.cnt;
      sb.push_back(n);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, {DW{1'b1}}, 1'b1);
      tick();
      checks++;
      if (out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== '0 || out_count !== '0 ||
          busy !== 1'b0) begin
        errors++;
        $display("FAIL reset cyc=%0d got v=%b l=%b c=%0d b=%b d=%h, required all zero",
                 cyc, out_valid, out_last, out_count, busy, out_data);
      end
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, '0, 1'b0);
      tick();
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || out_count !== '0) begin
        errors++;
        $display("FAIL reset_release cyc=%0d got v=%b b=%b c=%0d, required 0 0 0",
                 cyc, out_valid, busy, out_count);
      end
    end
    e.cyc = 0;
  endtask

  task automatic test_single();
    exp_t          e;
    logic [DW-1:0] w;
    int            seen = 0;
    for (int k = 0; k < LANES; k++) w[k*WIDTH +: WIDTH] = WIDTH'(k);
    for (int i = 0; i < 20; i++) begin
      drive(i == 1, 1'b0, w, i == 0);
      tick();
      if (sb.size() != 0 && sb[0].cyc == cyc) begin
        e = sb.pop_front();
        idle_cnt = e.last ? '0 : e.cnt;
        seen++;
        checks++;
        if (out_valid !== 1'b1 || out_last !== e.last || out_data !== e.data ||
            out_count !== e.cnt || busy !== (sb.size() != 0)) begin
          errors++;
          $display("FAIL single cyc=%0d got v=%b l=%b c=%0d b=%b d=%h, required v=1 l=%b c=%0d b=%b d=%h",
                   cyc, out_valid, out_last, out_count, busy, out_data,
                   e.last, e.cnt, sb.size() != 0, e.data);
        end
      end else begin
        checks++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== '0 ||
            out_count !== idle_cnt || busy !== (sb.size() != 0)) begin
          errors++;
          $display("FAIL single_idle cyc=%0d got v=%b l=%b c=%0d b=%b d=%h, required v=0 l=0 c=%0d b=%b d=0",
                   cyc, out_valid, out_last, out_count, busy, out_data, idle_cnt, sb.size() != 0);
        end
      end
    end
    checks++;
    if (seen !== 1) begin
      errors++;
      $display("FAIL single_count got %0d vectors, required 1", seen);
    end
  endtask

  task automatic test_frame();
    exp_t          e;
    logic [DW-1:0] w;
    for (int i = 0; i < 24; i++) begin
      w = '0;
      for (int k = 0; k < LANES; k++) w[k*WIDTH +: WIDTH] = WIDTH'(i);
      drive(i >= 1 && i <= 4, i == 4, w, i == 0);
      tick();
      if (sb.size() != 0 && sb[0].cyc == cyc) begin
        e = sb.pop_front();
        idle_cnt = e.last ? '0 : e.cnt;
        checks++;
        if (out_valid !== 1'b1 || out_last !== e.last || out_data !== e.data ||
            out_count !== e.cnt || busy !== (sb.size() != 0)) begin
          errors++;
          $display("FAIL frame cyc=%0d got v=%b l=%b c=%0d b=%b d=%h, required v=1 l=%b c=%0d b=%b d=%h",
                   cyc, out_valid, out_last, out_count, busy, out_data,
                   e.last, e.cnt, sb.size() != 0, e.data);
        end
      end else begin
        checks++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== '0 ||
            out_count !== idle_cnt || busy !== (sb.size() != 0)) begin
          errors++;
          $display("FAIL frame_idle cyc=%0d got v=%b l=%b c=%0d b=%b d=%h, required v=0 l=0 c=%0d b=%b d=0",
                   cyc, out_valid, out_last, out_count, busy, out_data, idle_cnt, sb.size() != 0);
        end
      end
    end
    checks++;
    if (out_count !== '0) begin
      errors++;
      $display("FAIL frame_count_clear got %0d, required 0", out_count);
    end
  endtask

  task automatic test_gapped();
    exp_t          e;
    logic [95:0]   rnd;
    logic [4:0]    pat;
    pat = 5'b01101; // bit i = in_valid of step i+1: 1,0,1,1,0
    for (int i = 0; i < 24; i++) begin
      rnd = {$urandom(), $urandom(), $urandom()};
      drive(i >= 1 && i <= 5 && pat[i-1], 1'b0, rnd[DW-1:0], i == 0);
      tick();
      if (sb.size() != 0 && sb[0].cyc == cyc) begin
        e = sb.pop_front();
        idle_cnt = e.last ? '0 : e.cnt;
        checks++;
        if (out_valid !== 1'b1 || out_last !== e.last || out_data !== e.data ||
            out_count !== e.cnt || busy !== (sb.size() != 0)) begin
          errors++;
          $display("FAIL gapped cyc=%0d got v=%b l=%b c=%0d b=%b d=%h, required v=1 l=%b c=%0d b=%b d=%h",
                   cyc, out_valid, out_last, out_count, busy, out_data,
                   e.last, e.cnt, sb.size() != 0, e.data);
        end
      end else begin
        checks++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== '0 ||
            out_count !== idle_cnt || busy !== (sb.size() != 0)) begin
          errors++;
          $display("FAIL gapped_idle cyc=%0d got v=%b l=%b c=%0d b=%b d=%h, required v=0 l=0 c=%0d b=%b d=0",
                   cyc, out_valid, out_last, out_count, busy, out_data, idle_cnt, sb.size() != 0);
        end
      end
    end
  endtask

  task automatic test_reset_midflight();
    exp_t        e;
    logic [95:0] rnd;
    int          seen = 0;
    for (int i = 0; i < 32; i++) begin
      rnd = {$urandom(), $urandom(), $urandom()};
      // Launch at step 1, reset at step 9 (8 cycles later), relaunch at step 11.
      drive(i == 1 || i == 11, 1'b0, rnd[DW-1:0], i == 0 || i == 9);
      tick();
      if (sb.size() != 0 && sb[0].cyc == cyc) begin
        e = sb.pop_front();
        idle_cnt = e.last ? '0 : e.cnt;
        seen++;
        checks++;
        if (out_valid !== 1'b1 || out_last !== e.last || out_data !== e.data ||
            out_count !== e.cnt || busy !== (sb.size() != 0)) begin
          errors++;
          $display("FAIL midreset cyc=%0d got v=%b l=%b c=%0d b=%b d=%h, required v=1 l=%b c=%0d b=%b d=%h",
                   cyc, out_valid, out_last, out_count, busy, out_data,
                   e.last, e.cnt, sb.size() != 0, e.data);
        end
      end else begin
        checks++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== '0 ||
            out_count !== idle_cnt || busy !== (sb.size() != 0)) begin
          errors++;
          $display("FAIL midreset_idle cyc=%0d got v=%b l=%b c=%0d b=%b d=%h, required v=0 l=0 c=%0d b=%b d=0",
                   cyc, out_valid, out_last, out_count, busy, out_data, idle_cnt, sb.size() != 0);
        end
      end
    end
    checks++;
    if (seen !== 1) begin
      errors++;
      $display("FAIL midreset_count got %0d vectors, required 1", seen);
    end
  endtask

  task automatic test_loopback();
    exp_t        e;
    logic [95:0] rnd;
    for (int i = 0; i < 1000 + LANES + 4; i++) begin
      rnd = {$urandom(), $urandom(), $urandom()};
      drive(i >= 1 && i <= 1000, ($urandom_range(0, 15) == 0), rnd[DW-1:0], i == 0);
      tick();
      if (sb.size() != 0 && sb[0].cyc == cyc) begin
        e = sb.pop_front();
        idle_cnt = e.last ? '0 : e.cnt;
        checks++;
        if (out_valid !== 1'b1 || out_last !== e.last || out_data !== e.data ||
            out_count !== e.cnt || busy !== (sb.size() != 0)) begin
          errors++;
          $display("FAIL loopback cyc=%0d got v=%b l=%b c=%0d b=%b d=%h, required v=1 l=%b c=%0d b=%b d=%h",
                   cyc, out_valid, out_last, out_count, busy, out_data,
                   e.last, e.cnt, sb.size() != 0, e.data);
        end
      end else begin
        checks++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== '0 ||
            out_count !== idle_cnt || busy !== (sb.size() != 0)) begin
          errors++;
          $display("FAIL loopback_idle cyc=%0d got v=%b l=%b c=%0d b=%b d=%h, required v=0 l=0 c=%0d b=%b d=0",
                   cyc, out_valid, out_last, out_count, busy, out_data, idle_cnt, sb.size() != 0);
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL loopback_drain got %0d vectors outstanding, required 0", sb.size());
    end
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
    for (int i = 0; i < LANES; i++) hist[i] = '0;
    test_reset();
    test_single();
    test_frame();
    test_gapped();
    test_reset_midflight();
    test_loopback();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
